booth_mul_arbiter: RTL and testbench
====================================

BOOTH_MUL_ARBITER -- requirements
Module: booth_mul_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; product width is 2*WIDTH.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Port: req0_valid  input  1  requester 0 has an operand pair.
REQ-005 Port: req0_a, req0_b  input  WIDTH each  requester 0 multiplicand and multiplier, two's complement.
REQ-006 Port: req0_ready  output  1  requester 0 operands accepted this cycle.
REQ-007 Port: req1_valid, req1_a, req1_b, req1_ready  same directions, widths and meanings as the requester 0 ports, for requester 1.
REQ-008 Port: rsp_valid  output  1  product available.
REQ-009 Port: rsp_id  output  1  index of the requester that owns the product.
REQ-010 Port: rsp_product  output  2*WIDTH  signed product.
REQ-011 Port: rsp_ready  input  1  consumer accepts the product.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: count  output  $clog2(WIDTH)  current Booth iteration index.

Function
REQ-014 The block shall arbitrate one iterative radix-2 Booth multiplier between two requesters.
REQ-015 The FSM shall have exactly three states:
- IDLE: waits for a request.
- RUN: performs one Booth step per cycle.
- DONE: holds the result until it is accepted.
REQ-016 In IDLE with at least one reqN_valid high, the block shall select a grant and assert only the granted reqN_ready, combinationally, in that same cycle.
REQ-017 When both requesters are valid in IDLE, the block shall grant the requester named by a round-robin pointer.
- If only one requester is valid, that requester is granted regardless of the pointer.
REQ-018 Acceptance occurs on a clock edge where reqN_valid and reqN_ready are both high. On that edge the block shall:
- load M = a, Q = b, A = 0, Q_1 = 0, count = 0;
- record the grant index;
- move to RUN.
REQ-019 Accumulator A shall be WIDTH+1 bits wide so that the most-negative multiplicand is handled without overflow.
REQ-020 Each RUN cycle shall update A per {Q[0], Q_1}, then arithmetic-shift {A, Q, Q_1} right by 1:
- 01: A + M.
- 10: A - M.
- 00 or 11: no change.
REQ-021 In RUN, count shall increment by 1 per step.
- After the step taken at count == WIDTH-1, the FSM shall enter DONE and count shall wrap to 0.
REQ-022 rsp_valid shall first assert exactly WIDTH clock edges after the accepting edge.
REQ-023 In DONE, rsp_product shall be {A[WIDTH-1:0], Q}, which equals the signed product a*b.
- rsp_id shall equal the recorded grant index.
- Both shall be held stable while rsp_ready is low.
REQ-024 On a clock edge with rsp_valid and rsp_ready both high, the FSM shall return to IDLE and the round-robin pointer shall be set to the non-served requester.
REQ-025 In RUN and DONE, req0_ready and req1_ready shall be 0.
- Requests arriving then are not dropped; a requester must hold valid and operands until it sees ready.
REQ-026 rsp_valid shall be 0 in IDLE and RUN.
- rsp_product and rsp_id shall read 0 whenever rsp_valid is 0.
REQ-027 Minimum issue interval shall be WIDTH+2 cycles, because one IDLE cycle is required between operations.

Reset
REQ-028 While reset is high at a clock edge, the block shall set:
- state to IDLE;
- A, M, Q, Q_1, count, grant index and round-robin pointer to 0.
REQ-029 During and after reset, every output shall be 0.
REQ-030 Reset asserted in RUN or DONE shall abort the operation with no response.
- The first request after reset shall be arbitrated with the pointer at 0.
REQ-031 reset shall take priority over any handshake occurring on the same edge.

Structure
REQ-032 A shared package shall hold the FSM state enumeration (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-033 The Booth step datapath shall be a sub-module named booth_step_unit.
- It is combinational.
- Inputs: A, Q, Q_1, M.
- Outputs: next A, Q, Q_1.
- The arbiter holds all registers.

Verification
REQ-034 Bench: req0 a=3, b=-2 (4'hE), rsp_ready=1 -> rsp_valid 4 edges after accept, rsp_product=8'hFA, rsp_id=0.
REQ-035 Bench: req1 a=-8, b=-8 -> rsp_product=8'h40; req1 a=7, b=-8 -> rsp_product=8'hC8.
REQ-036 Bench: both valid from reset, req0 2*3, req1 -1*5 -> req0 served first with 8'h06, then req1 with 8'hFB, rsp_id sequence 0,1.
REQ-037 Bench: rsp_ready held low 10 cycles in DONE -> rsp_valid, rsp_product and rsp_id stable; req ready stays 0; pending req0 accepted the cycle after the response handshake.
REQ-038 Bench: reset pulsed at count=2 in RUN -> next cycle all outputs 0 and busy=0; a new request 5*5 then yields 8'h19.

Source files
------------

// File: rtl/booth_mul_arbiter_pkg.sv
// Shared types for the two-requester Booth multiplier arbiter.
// Holds the FSM state encoding and the default operand width.
package booth_mul_arbiter_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/booth_mul_arbiter_step.sv
// booth_step_unit: one combinational radix-2 Booth step.
// Ports: a/q/q_1/m in, a_next/q_next/q_1_next out (add/sub then arith shift).
module booth_step_unit #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH:0]   a,
  input  logic [WIDTH-1:0] q,
  input  logic             q_1,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH:0]   a_next,
  output logic [WIDTH-1:0] q_next,
  output logic             q_1_next
);

  logic [WIDTH:0] mx;
  logic [WIDTH:0] sum;

  // Sign-extend M so the most-negative multiplicand fits in A.
  assign mx = {m[WIDTH-1], m};

  always_comb begin
    sum = a;
    unique case ({q[0], q_1})
      2'b01:   sum = a + mx;
      2'b10:   sum = a - mx;
      default: sum = a;
    endcase
  end

  // Arithmetic right shift of {sum, q, q_1}.
  assign a_next   = {sum[WIDTH], sum[WIDTH:1]};
  assign q_next   = {sum[0], q[WIDTH-1:1]};
  assign q_1_next = q[0];

endmodule

// File: rtl/booth_mul_arbiter.sv
// booth_mul_arbiter: round-robin share of one iterative Booth multiplier.
// Ports: clk/reset, req0/req1 valid-ready operand pairs, rsp valid-ready product, busy, count.
module booth_mul_arbiter
  import booth_mul_arbiter_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_product,
  input  logic               rsp_ready,
  output logic               busy,
  output logic [CW-1:0]      count
);

  state_t state, state_n;

  logic [WIDTH:0]   a_q;
  logic [WIDTH-1:0] m_q;
  logic [WIDTH-1:0] q_q;
  logic             q1_q;
  logic [CW-1:0]    cnt_q;
  logic             id_q;
  logic             ptr_q;

  logic [WIDTH:0]   a_s;
  logic [WIDTH-1:0] q_s;
  logic             q1_s;

  logic gnt;
  logic r0;
  logic r1;
  logic last;
  logic done;

  booth_step_unit #(.WIDTH(WIDTH)) u_step (
    .a        (a_q),
    .q        (q_q),
    .q_1      (q1_q),
    .m        (m_q),
    .a_next   (a_s),
    .q_next   (q_s),
    .q_1_next (q1_s)
  );

  assign last = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_n = state;
    gnt     = 1'b0;
    r0      = 1'b0;
    r1      = 1'b0;
    unique case (state)
      IDLE: begin
        // Pointer only matters when both requesters compete.
        gnt = (req0_valid && req1_valid) ? ptr_q : req1_valid;
        if (!reset) begin
          r0 = req0_valid && !gnt;
          r1 = req1_valid && gnt;
        end
        if (r0 || r1) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        if (rsp_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      a_q   <= '0;
      m_q   <= '0;
      q_q   <= '0;
      q1_q  <= 1'b0;
      cnt_q <= '0;
      id_q  <= 1'b0;
      ptr_q <= 1'b0;
    end else begin
      state <= state_n;
      unique case (state)
        IDLE: begin
          if (r0 || r1) begin
            m_q   <= r1 ? req1_a : req0_a;
            q_q   <= r1 ? req1_b : req0_b;
            a_q   <= '0;
            q1_q  <= 1'b0;
            cnt_q <= '0;
            id_q  <= r1;
          end
        end
        RUN: begin
          a_q   <= a_s;
          q_q   <= q_s;
          q1_q  <= q1_s;
          cnt_q <= last ? '0 : cnt_q + 1'b1;
        end
        DONE: begin
          if (rsp_ready) ptr_q <= ~id_q;
        end
        default: ;
      endcase
    end
  end

  // Outputs are forced to 0 while reset is asserted.
  assign done        = (state == DONE) && !reset;
  assign req0_ready  = r0;
  assign req1_ready  = r1;
  assign rsp_valid   = done;
  assign rsp_id      = done & id_q;
  assign rsp_product = done ? {a_q[WIDTH-1:0], q_q} : '0;
  assign busy        = (state != IDLE) && !reset;
  assign count       = reset ? '0 : cnt_q;

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: transaction-level model plus directed vectors.
// Compares every output each cycle and pins the model with literal products.
module tb_booth_mul_arbiter;

  localparam int W  = 4;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          v0 = 1'b0;
  logic          v1 = 1'b0;
  logic [W-1:0]  a0 = '0;
  logic [W-1:0]  b0 = '0;
  logic [W-1:0]  a1 = '0;
  logic [W-1:0]  b1 = '0;
  logic          rsp_ready = 1'b0;
  logic          req0_ready;
  logic          req1_ready;
  logic          rsp_valid;
  logic          rsp_id;
  logic [PW-1:0] rsp_product;
  logic          busy;
  logic [1:0]    count;

  booth_mul_arbiter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (v0),
    .req0_a      (a0),
    .req0_b      (b0),
    .req0_ready  (req0_ready),
    .req1_valid  (v1),
    .req1_a      (a1),
    .req1_b      (b1),
    .req1_ready  (req1_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_product (rsp_product),
    .rsp_ready   (rsp_ready),
    .busy        (busy),
    .count       (count)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit started = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Model: age = edges since acceptance, -1 when no operation is in flight.
  int            age = -1;
  bit            ptr = 0;
  bit            mid = 0;
  logic [PW-1:0] mprod = '0;

  function automatic bit exp_r0();
    return !reset && age < 0 && v0 && (!v1 || !ptr);
  endfunction

  function automatic bit exp_r1();
    return !reset && age < 0 && v1 && (!v0 || ptr);
  endfunction

  always @(posedge clk) begin
    bit e0, e1;
    int pa, pb;
    e0 = exp_r0();
    e1 = exp_r1();
    cyc++;
    if (reset) begin
      age = -1;
      ptr = 0;
    end else if (age < 0) begin
      if (e0 || e1) begin
        pa    = e1 ? int'($signed(a1)) : int'($signed(a0));
        pb    = e1 ? int'($signed(b1)) : int'($signed(b0));
        mprod = PW'(pa * pb);
        mid   = e1;
        age   = 0;
      end
    end else if (age < W) begin
      age++;
    end else if (rsp_ready) begin
      age = -1;
      ptr = !mid;
    end
  end

  always @(negedge clk) begin
    bit ev;
    if (started) begin
      ev = !reset && age >= W;
      chk("req0_ready", 32'(req0_ready), 32'(exp_r0()));
      chk("req1_ready", 32'(req1_ready), 32'(exp_r1()));
      chk("rsp_valid", 32'(rsp_valid), 32'(ev));
      chk("rsp_id", 32'(rsp_id), ev ? 32'(mid) : 32'd0);
      chk("rsp_product", 32'(rsp_product), ev ? 32'(mprod) : 32'd0);
      chk("busy", 32'(busy), 32'(!reset && age >= 0));
      chk("count", 32'(count),
          (!reset && age >= 0 && age < W) ? 32'(age) : 32'd0);
    end
  end

  // Handshake log: accept edges, first-valid latency, responses.
  bit   take0 = 0;
  bit   take1 = 0;
  bit   seen_v = 1;
  int   acc_edge = 0;
  int   acc0_edge = 0;
  int   lat_q[$];
  int   hs_q[$];
  logic id_q[$];
  logic [PW-1:0] pr_q[$];

  always @(negedge clk) begin
    take0 = v0 && req0_ready;
    take1 = v1 && req1_ready;
    if (take0 || take1) begin
      acc_edge = cyc + 1;
      seen_v   = 0;
    end
    if (take0) acc0_edge = cyc + 1;
    if (rsp_valid && !seen_v) begin
      lat_q.push_back(cyc - acc_edge);
      seen_v = 1;
    end
    if (rsp_valid && rsp_ready) begin
      id_q.push_back(rsp_id);
      pr_q.push_back(rsp_product);
      hs_q.push_back(cyc + 1);
    end
  end

  // Requesters drop valid right after being accepted.
  always @(posedge clk) begin
    #1;
    if (take0) v0 = 1'b0;
    if (take1) v1 = 1'b0;
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    int t;
    t = 0;
    while (id_q.size() < n && t < 200) begin
      @(posedge clk);
      t++;
    end
    #1;
    chk("rsp_count", 32'(id_q.size()), 32'(n));
  endtask

  initial begin
    int t;
    @(posedge clk);
    started = 1;
    cycles(1);
    reset = 1'b0;

    // 3 * -2 from requester 0
    rsp_ready = 1'b1;
    a0 = 4'd3; b0 = 4'hE; v0 = 1'b1;
    wait_n(1);
    if (lat_q.size() > 0) chk("latency", 32'(lat_q[0]), 32'd4);
    if (pr_q.size() > 0) begin
      chk("p_3x-2", 32'(pr_q[0]), 32'h0FA);
      chk("id_3x-2", 32'(id_q[0]), 32'd0);
    end

    // -8 * -8 and 7 * -8 from requester 1
    a1 = 4'h8; b1 = 4'h8; v1 = 1'b1;
    wait_n(2);
    a1 = 4'h7; b1 = 4'h8; v1 = 1'b1;
    wait_n(3);
    if (pr_q.size() > 2) begin
      chk("p_-8x-8", 32'(pr_q[1]), 32'h040);
      chk("id_-8x-8", 32'(id_q[1]), 32'd1);
      chk("p_7x-8", 32'(pr_q[2]), 32'h0C8);
    end

    // both valid straight out of reset
    reset = 1'b1;
    a0 = 4'd2; b0 = 4'd3; a1 = 4'hF; b1 = 4'd5;
    v0 = 1'b1; v1 = 1'b1;
    cycles(1);
    reset = 1'b0;
    wait_n(5);
    if (pr_q.size() > 4) begin
      chk("rr_id0", 32'(id_q[3]), 32'd0);
      chk("rr_p0", 32'(pr_q[3]), 32'h006);
      chk("rr_id1", 32'(id_q[4]), 32'd1);
      chk("rr_p1", 32'(pr_q[4]), 32'h0FB);
    end

    // hold DONE with rsp_ready low while req0 waits
    rsp_ready = 1'b0;
    a1 = 4'd2; b1 = 4'hD; v1 = 1'b1;
    cycles(2);
    a0 = 4'hD; b0 = 4'd4; v0 = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!rsp_valid && t < 20);
    chk("hold_reach", 32'(rsp_valid), 32'd1);
    repeat (10) @(negedge clk);
    chk("hold_valid", 32'(rsp_valid), 32'd1);
    chk("hold_p", 32'(rsp_product), 32'h0FA);
    chk("hold_id", 32'(rsp_id), 32'd1);
    chk("hold_r0", 32'(req0_ready), 32'd0);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    wait_n(7);
    if (pr_q.size() > 6 && hs_q.size() > 5) begin
      chk("pend_acc", 32'(acc0_edge - hs_q[5]), 32'd1);
      chk("pend_p", 32'(pr_q[6]), 32'h0F4);
      chk("pend_id", 32'(id_q[6]), 32'd0);
    end

    // reset in the middle of RUN
    a0 = 4'd6; b0 = 4'd7; v0 = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(busy && count == 2'd2) && t < 20);
    chk("abort_reach", 32'(count), 32'd2);
    #2;
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_valid", 32'(rsp_valid), 32'd0);
    chk("abort_count", 32'(count), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    a0 = 4'd5; b0 = 4'd5; v0 = 1'b1;
    wait_n(8);
    if (pr_q.size() > 7) begin
      chk("p_5x5", 32'(pr_q[7]), 32'h019);
      chk("id_5x5", 32'(id_q[7]), 32'd0);
    end

    cycles(2);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
